// File: rtl/ahb_modexp_ctrl_if.sv
`default_nettype none
// ============================================================================
// ahb_modexp_ctrl_if : AHB-Lite bus bundle between a master and ahb_modexp_ctrl
// Rev 1.0
// ============================================================================
interface ahb_modexp_ctrl_if;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic        HREADYOUT;
    logic [1:0]  HRESP;
    logic [31:0] HRDATA;

    modport master (
        output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
        input  HREADYOUT, HRESP, HRDATA
    );

    modport slave (
        input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
        output HREADYOUT, HRESP, HRDATA
    );
endinterface
`default_nettype wire

// File: rtl/ahb_modexp_ctrl.sv
`default_nettype none
// ============================================================================
// ahb_modexp_ctrl : AHB-Lite sequencer loading/starting/unloading the modexp core
// Rev 1.0
// ============================================================================
module ahb_modexp_ctrl #(
    parameter int WORDS = 64,
    parameter int OP_W  = 2048
) (
    input  wire              HCLK,
    input  wire              HRESETn,
    ahb_modexp_ctrl_if.slave bus,
    output logic             IRQ,
    output logic             core_start,
    output logic [OP_W-1:0]  core_x,
    input  wire              core_done,
    input  wire  [OP_W-1:0]  core_y
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    // DATA lives at 0x10, so the word index needs HADDR[4:2] to separate it from CTRL
    localparam logic [2:0] A_CTRL    = 3'd0;
    localparam logic [2:0] A_STATUS  = 3'd1;
    localparam logic [2:0] A_DATA    = 3'd4;
    localparam logic [6:0] LAST_WORD = 7'(WORDS - 1);

    state_t          state;
    state_t          state_nx;
    logic            dp_valid;
    logic            dp_write;
    logic [2:0]      dp_addr;
    logic [6:0]      ld_cnt;
    logic [6:0]      rd_cnt;
    logic            err;
    logic            irq_en;
    logic [OP_W-1:0] result;
    logic [31:0]     rdata;

    logic addr_ph, wr_ctrl, wr_data, rd_data, arm;
    logic load_fire, load_last, rd_fire;
    logic unused_bits;

    assign addr_ph = bus.HSEL & bus.HTRANS[1] & bus.HREADY;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            dp_valid <= 1'b0;
            dp_write <= 1'b0;
            dp_addr  <= '0;
        end else if (bus.HREADY) begin
            dp_valid <= addr_ph;
            if (addr_ph) begin
                dp_write <= bus.HWRITE;
                dp_addr  <= bus.HADDR[4:2];
            end
        end
    end

    assign wr_ctrl   = dp_valid &  dp_write & (dp_addr == A_CTRL);
    assign wr_data   = dp_valid &  dp_write & (dp_addr == A_DATA);
    assign rd_data   = dp_valid & ~dp_write & (dp_addr == A_DATA);
    assign arm       = wr_ctrl & bus.HWDATA[0];
    assign load_fire = wr_data & (state == LOAD);
    assign load_last = load_fire & (ld_cnt == LAST_WORD);
    assign rd_fire   = rd_data & (state == DONE);

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Arming is honoured everywhere except RUN; the core is never aborted
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (arm)       state_nx = LOAD;
            LOAD:    if (load_last) state_nx = RUN;
            RUN:     if (core_done) state_nx = DONE;
            DONE:    if (arm)       state_nx = LOAD;
            default:                state_nx = IDLE;
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            core_start <= 1'b0;
            core_x     <= '0;
            ld_cnt     <= '0;
            rd_cnt     <= '0;
            err        <= 1'b0;
            irq_en     <= 1'b0;
            result     <= '0;
        end else begin
            core_start <= load_last;
            if (wr_ctrl) begin
                irq_en <= bus.HWDATA[1];
            end
            if (arm && state != RUN) begin
                ld_cnt <= '0;
                rd_cnt <= '0;
                err    <= 1'b0;
            end else if (arm || (wr_data && state != LOAD)) begin
                err <= 1'b1;
            end
            // Shift in from the top so the first word ends up in the LSW
            if (load_fire) begin
                core_x <= {bus.HWDATA, core_x[OP_W-1:32]};
                ld_cnt <= load_last ? 7'd0 : ld_cnt + 7'd1;
            end
            if (state == RUN && core_done) begin
                result <= core_y;
            end else if (rd_fire) begin
                result <= {result[31:0], result[OP_W-1:32]};
                rd_cnt <= (rd_cnt == LAST_WORD) ? 7'd0 : rd_cnt + 7'd1;
            end
        end
    end

    always_comb begin
        rdata = '0;
        if (dp_valid && !dp_write) begin
            case (dp_addr)
                A_CTRL:   rdata = {30'b0, irq_en, 1'b0};
                A_STATUS: rdata = {17'b0, ld_cnt, 5'b0, err,
                                   (state == LOAD) || (state == RUN),
                                   (state == DONE)};
                A_DATA:   rdata = (state == DONE) ? result[31:0] : 32'h0;
                default:  rdata = '0;
            endcase
        end
    end

    assign bus.HRDATA    = rdata;
    assign bus.HREADYOUT = 1'b1;
    assign bus.HRESP     = 2'b00;
    assign IRQ           = (state == DONE) & irq_en;

    assign unused_bits = &{1'b0, bus.HADDR[31:5], bus.HADDR[1:0],
                           bus.HTRANS[0], bus.HSIZE};

endmodule
`default_nettype wire

// File: tb/tb_ahb_modexp_ctrl.sv
`default_nettype none
// ============================================================================
// tb_ahb_modexp_ctrl : directed bench for ahb_modexp_ctrl with a stub core (y = x + 5)
// Rev 1.0
// ============================================================================
module tb_ahb_modexp_ctrl;
    localparam int WORDS = 64;
    localparam int OP_W  = 2048;
    localparam logic [31:0] A_CTRL   = 32'h00;
    localparam logic [31:0] A_STATUS = 32'h04;
    localparam logic [31:0] A_RSVD   = 32'h08;
    localparam logic [31:0] A_DATA   = 32'h10;

    logic            HCLK = 1'b0;
    logic            HRESETn = 1'b0;
    logic            IRQ;
    logic            core_start;
    logic [OP_W-1:0] core_x;
    logic [OP_W-1:0] core_y;
    logic            core_done;
    logic            stub_done;
    logic            spur_done = 1'b0;
    int              stub_cnt;
    logic            stub_busy;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int start_cnt = 0;
    int start_cyc = -1;
    int last_dp_cyc = 0;

    logic [OP_W-1:0] opp, opa, opb, opc, expp, expa, expb, expc;

    ahb_modexp_ctrl_if bus();

    ahb_modexp_ctrl #(.WORDS(WORDS), .OP_W(OP_W)) dut (
        .HCLK       (HCLK),
        .HRESETn    (HRESETn),
        .bus        (bus),
        .IRQ        (IRQ),
        .core_start (core_start),
        .core_x     (core_x),
        .core_done  (core_done),
        .core_y     (core_y)
    );

    always #5 HCLK = ~HCLK;
    assign bus.HREADY = bus.HREADYOUT;
    assign core_done  = stub_done | spur_done;

    always @(posedge HCLK) cyc <= cyc + 1;

    always @(negedge HCLK) begin
        if (core_start === 1'b1) begin
            start_cnt <= start_cnt + 1;
            start_cyc <= cyc;
        end
    end

    // Stub core: answers core_x + 5 about 100 cycles after the start pulse
    always @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            stub_cnt  <= 0;
            stub_busy <= 1'b0;
            stub_done <= 1'b0;
            core_y    <= '0;
        end else begin
            stub_done <= 1'b0;
            if (core_start) begin
                stub_busy <= 1'b1;
                stub_cnt  <= 0;
            end else if (stub_busy) begin
                if (stub_cnt == 99) begin
                    stub_done <= 1'b1;
                    core_y    <= core_x + OP_W'(5);
                    stub_busy <= 1'b0;
                end else begin
                    stub_cnt <= stub_cnt + 1;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic idle_bus();
        bus.HSEL   = 1'b0;
        bus.HTRANS = 2'b00;
        bus.HWRITE = 1'b0;
    endtask

    task automatic ahb_write(input logic [31:0] a, input logic [31:0] d);
        @(posedge HCLK); #1;
        bus.HSEL = 1'b1; bus.HTRANS = 2'b10; bus.HWRITE = 1'b1; bus.HADDR = a;
        @(posedge HCLK); #1;
        idle_bus();
        bus.HWDATA = d;
    endtask

    task automatic ahb_read(input logic [31:0] a, output logic [31:0] d);
        @(posedge HCLK); #1;
        bus.HSEL = 1'b1; bus.HTRANS = 2'b10; bus.HWRITE = 1'b0; bus.HADDR = a;
        @(posedge HCLK); #1;
        idle_bus();
        @(negedge HCLK);
        d = bus.HRDATA;
    endtask

    // CTRL write followed by n DATA writes, every address phase overlapping the previous data phase
    task automatic arm_and_load(input logic [31:0] ctrl, input logic [OP_W-1:0] v, input int n);
        @(posedge HCLK); #1;
        bus.HSEL = 1'b1; bus.HTRANS = 2'b10; bus.HWRITE = 1'b1; bus.HADDR = A_CTRL;
        for (int i = 0; i <= n; i++) begin
            @(posedge HCLK); #1;
            if (i == 0) bus.HWDATA = ctrl;
            else        bus.HWDATA = v[32*(i-1) +: 32];
            if (i < n) begin
                bus.HADDR = A_DATA; bus.HTRANS = 2'b10;
            end else begin
                idle_bus();
            end
            last_dp_cyc = cyc;
        end
    endtask

    task automatic read_burst(input logic [OP_W-1:0] expv, input string tag);
        @(posedge HCLK); #1;
        bus.HSEL = 1'b1; bus.HTRANS = 2'b10; bus.HWRITE = 1'b0; bus.HADDR = A_DATA;
        for (int k = 0; k < WORDS; k++) begin
            @(posedge HCLK); #1;
            if (k == WORDS - 1) idle_bus();
            @(negedge HCLK);
            check($sformatf("%s_word%0d", tag, k), bus.HRDATA, expv[32*k +: 32]);
        end
    endtask

    task automatic poll_done(input logic [31:0] exp_busy, input logic [31:0] exp_done, input string tag);
        logic [31:0] s;
        int n;
        ahb_read(A_STATUS, s);
        check({tag, "_poll_first"}, s, exp_busy);
        n = 0;
        while (!s[0] && n < 200) begin
            ahb_read(A_STATUS, s);
            n++;
        end
        check({tag, "_poll_done"}, s, exp_done);
    endtask

    task automatic wait_core_done();
        int n;
        n = 0;
        do begin
            @(negedge HCLK);
            n++;
        end while (core_done !== 1'b1 && n < 300);
        check("core_done_seen", 32'(core_done), 32'h1);
    endtask

    initial begin
        logic [31:0] r;
        int base;
        for (int k = 0; k < WORDS; k++) begin
            opp[32*k +: 32] = 32'(k + 1);
            opa[32*k +: 32] = 32'hA000_0000 + 32'(k);
            opb[32*k +: 32] = (k == 0) ? 32'hFFFF_FFFF : 32'h1234_0000 + 32'(k);
            opc[32*k +: 32] = 32'(k * 256);
        end
        expp = opp; expp[31:0] = 32'h6;
        expa = opa; expa[31:0] = 32'hA000_0005;
        expb = opb; expb[31:0] = 32'h4; expb[63:32] = 32'h1234_0002;
        expc = opc; expc[31:0] = 32'h5;

        bus.HADDR = '0; bus.HWDATA = '0; bus.HSIZE = 3'b010;
        idle_bus();
        repeat (3) @(posedge HCLK);
        @(negedge HCLK) HRESETn = 1'b1;

        @(negedge HCLK);
        check("rst_irq", 32'(IRQ), 32'h0);
        check("rst_core_start", 32'(core_start), 32'h0);
        check("rst_core_x_lo", core_x[31:0], 32'h0);
        check("rst_hrdata", bus.HRDATA, 32'h0);
        ahb_read(A_CTRL, r);   check("rst_ctrl", r, 32'h0);
        ahb_read(A_STATUS, r); check("rst_status", r, 32'h0);
        ahb_read(A_RSVD, r);   check("rsvd_read", r, 32'h0);

        @(posedge HCLK); #1 spur_done = 1'b1;
        @(posedge HCLK); #1 spur_done = 1'b0;
        ahb_read(A_STATUS, r); check("spurious_done_idle", r, 32'h0);

        // Reset in the middle of a load
        base = start_cnt;
        arm_and_load(32'h1, opp, 10);
        ahb_read(A_STATUS, r); check("ld10_status", r, 32'h0000_0A02);
        ahb_read(A_DATA, r);   check("data_read_in_load", r, 32'h0);
        @(posedge HCLK); #3 HRESETn = 1'b0;
        repeat (2) @(posedge HCLK);
        @(negedge HCLK) HRESETn = 1'b1;
        @(negedge HCLK);
        check("rst2_hrdata", bus.HRDATA, 32'h0);
        check("rst2_core_x_lo", core_x[31:0], 32'h0);
        ahb_read(A_STATUS, r); check("rst2_status", r, 32'h0);
        check("rst2_no_start", 32'(start_cnt - base), 32'h0);

        // DATA write while IDLE flags err
        ahb_write(A_DATA, 32'hDEAD_BEEF);
        ahb_read(A_STATUS, r); check("idle_write_err", r, 32'h4);
        check("idle_write_core_x", core_x[31:0], 32'h0);

        // Full load of words k+1
        base = start_cnt;
        arm_and_load(32'hFFFF_FFFF, opp, WORDS);
        ahb_read(A_STATUS, r); check("run_status", r, 32'h2);
        check("start_once", 32'(start_cnt - base), 32'h1);
        check("start_timing", 32'(start_cyc), 32'(last_dp_cyc + 1));
        check("core_x_lsw", core_x[31:0], 32'h1);
        check("core_x_msw", core_x[OP_W-1 -: 32], 32'h40);
        ahb_read(A_CTRL, r); check("ctrl_irq_en", r, 32'h2);
        poll_done(32'h2, 32'h1, "p");
        read_burst(expp, "p");
        ahb_read(A_DATA, r); check("p_wrap_word0", r, 32'h6);

        // IRQ timing and clearing by re-arm
        arm_and_load(32'h3, opa, WORDS);
        wait_core_done();
        check("irq_in_done_cycle", 32'(IRQ), 32'h0);
        @(negedge HCLK);
        check("irq_after_done", 32'(IRQ), 32'h1);
        ahb_write(A_CTRL, 32'h1);
        @(posedge HCLK); @(negedge HCLK);
        check("irq_cleared", 32'(IRQ), 32'h0);
        ahb_read(A_STATUS, r); check("rearm_status", r, 32'h2);

        // Arm and DATA write during RUN are ignored but flagged
        arm_and_load(32'h1, opc, WORDS);
        ahb_write(A_CTRL, 32'h1);
        ahb_write(A_DATA, 32'h0000_DEAD);
        ahb_read(A_STATUS, r); check("run_arm_err", r, 32'h6);
        check("run_core_x_w0", core_x[31:0], 32'h0);
        check("run_core_x_w1", core_x[63:32], 32'h100);
        check("run_core_x_msw", core_x[OP_W-1 -: 32], 32'h3F00);
        poll_done(32'h6, 32'h5, "c");
        read_burst(expc, "c");

        // Two back-to-back operations
        base = start_cnt;
        arm_and_load(32'h1, opa, WORDS);
        ahb_read(A_STATUS, r); check("err_cleared_by_arm", r, 32'h2);
        poll_done(32'h2, 32'h1, "a");
        read_burst(expa, "a");
        arm_and_load(32'h1, opb, WORDS);
        poll_done(32'h2, 32'h1, "b");
        read_burst(expb, "b");
        check("b2b_start_count", 32'(start_cnt - base), 32'h2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1);
    end

endmodule
`default_nettype wire
